// File: rtl/mux_arb_pkg.sv
// Shared definitions for the round-robin mux arbiter.
//   arb_state_t : arbitration FSM state (IDLE = no owner, BUSY = gnt[sel] held)
//   NUM_REQ     : number of requesters sharing the mux
//   rr_pick     : round-robin winner search; returns {found, idx[1:0]}
package mux_arb_pkg;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} arb_state_t;

  localparam int NUM_REQ = 4;

  // Scan last+1, last+2, last+3, last (mod 4) and return the first set bit.
  // The previous owner is checked last, so it has lowest priority.
  function automatic logic [2:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                         input logic [1:0]         last);
    logic       found;
    logic [1:0] idx;
    logic [1:0] cand;
    found = 1'b0;
    idx   = last;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = last + 2'(i);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    return {found, idx};
  endfunction

endpackage

// File: rtl/mux_rr_arbiter_mux4.sv
// Plain 4:1 data mux.
//   sel     : 2-bit select (0 = a, 1 = b, 2 = c, 3 = d)
//   a,b,c,d : DW-bit data inputs
//   y       : selected data
module mux_rr_arbiter_mux4 #(
  parameter int DW = 4
) (
  input  logic [1:0]    sel,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [DW-1:0] c,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] y
);

  always_comb begin
    y = a;
    case (sel)
      2'd0: y = a;
      2'd1: y = b;
      2'd2: y = c;
      2'd3: y = d;
      default: y = a;
    endcase
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 mux between four requesters.
// A grant is held for up to MAX_BURST transfers, or until the owner drops
// its request, then priority rotates past the owner.
//   clk, rst_n     : clock (rising edge) and async active-low reset
//   req[3:0]       : per-requester request (0=a, 1=b, 2=c, 3=d)
//   a, b, c, d     : requester data
//   gnt[3:0]       : one-hot owner, zero when idle
//   ack[3:0]       : one-hot per-transfer acknowledge
//   sel[1:0]       : registered mux select (index of the gnt bit)
//   y              : selected data, meaningful only while out_valid=1
//   out_valid      : downstream valid
//   out_ready      : downstream ready
//   state_dbg      : FSM state (0 = IDLE, 1 = BUSY)
//   burst_cnt_dbg  : transfers completed in the current grant
//
// Handshake: a transfer happens in every cycle where out_valid & out_ready
// are both high at the rising edge. out_valid follows req[sel] of the owner
// combinationally, so it may fall without a transfer if the owner withdraws;
// out_ready may change freely and stalls the owner without any timeout.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int DW        = 4,
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = $clog2(MAX_BURST + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       req,
  input  logic [DW-1:0]    a,
  input  logic [DW-1:0]    b,
  input  logic [DW-1:0]    c,
  input  logic [DW-1:0]    d,
  output logic [3:0]       gnt,
  output logic [3:0]       ack,
  output logic [1:0]       sel,
  output logic [DW-1:0]    y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             state_dbg,
  output logic [CNT_W-1:0] burst_cnt_dbg
);

  if (DW != 4) begin : g_dw_check
    $error("mux_rr_arbiter: DW must be 4");
  end
  if (MAX_BURST < 1 || MAX_BURST > 15) begin : g_burst_check
    $error("mux_rr_arbiter: MAX_BURST must be in 1..15");
  end

  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST);

  arb_state_t       state;
  logic [1:0]       last;
  logic [CNT_W-1:0] burst_cnt;

  logic             busy;
  logic             xfer;
  logic [CNT_W-1:0] cnt_inc;
  logic             rel_burst;
  logic             rel_drop;
  logic             release_now;
  logic [3:0]       own_bit;
  logic [3:0]       req_masked;
  logic [2:0]       idle_pick;
  logic [2:0]       rel_pick;

  assign busy      = (state == BUSY);
  assign own_bit   = 4'b0001 << sel;
  assign out_valid = busy & req[sel];
  assign xfer      = out_valid & out_ready;
  assign cnt_inc   = burst_cnt + CNT_W'(1);
  assign gnt       = busy ? own_bit : 4'b0000;
  assign ack       = xfer ? own_bit : 4'b0000;

  assign rel_burst   = xfer && (cnt_inc == BURST_LAST);
  assign rel_drop    = !req[sel];
  assign release_now = busy && (rel_burst || rel_drop);

  // On a burst-limit release the owner is removed from the search unless it
  // is the only one asking, in which case it is re-granted straight away.
  always_comb begin
    req_masked = req;
    if (rel_burst && ((req & ~own_bit) != 4'b0000)) begin
      req_masked = req & ~own_bit;
    end
  end

  // Idle search uses the stored pointer; release search uses the owner as
  // the new pointer, since last <= sel happens on the same edge.
  assign idle_pick = rr_pick(req, last);
  assign rel_pick  = rr_pick(req_masked, sel);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sel       <= 2'd0;
      last      <= 2'd3;
      burst_cnt <= '0;
    end else if (state == IDLE) begin
      if (idle_pick[2]) begin
        state     <= BUSY;
        sel       <= idle_pick[1:0];
        burst_cnt <= '0;
      end
    end else begin
      if (release_now) begin
        last      <= sel;
        burst_cnt <= '0;
        if (rel_pick[2]) begin
          sel <= rel_pick[1:0];
        end else begin
          state <= IDLE;
        end
      end else if (xfer) begin
        burst_cnt <= cnt_inc;
      end
    end
  end

  assign state_dbg     = state;
  assign burst_cnt_dbg = burst_cnt;

  mux_rr_arbiter_mux4 #(.DW(DW)) u_mux (
    .sel (sel),
    .a   (a),
    .b   (b),
    .c   (c),
    .d   (d),
    .y   (y)
  );

endmodule

// File: tb/tb_mux_rr_arbiter.sv
module tb_mux_rr_arbiter;

  localparam int DW = 4;

  logic          clk;
  logic          rst_n;
  logic [3:0]    req;
  logic [DW-1:0] a, b, c, d;
  logic [3:0]    gnt;
  logic [3:0]    ack;
  logic [1:0]    sel;
  logic [DW-1:0] y;
  logic          out_valid;
  logic          out_ready;
  logic          state_dbg;
  logic [2:0]    burst_cnt_dbg;

  int tests_run;
  int tests_failed;

  mux_rr_arbiter #(.DW(4), .MAX_BURST(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req           (req),
    .a             (a),
    .b             (b),
    .c             (c),
    .d             (d),
    .gnt           (gnt),
    .ack           (ack),
    .sel           (sel),
    .y             (y),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .state_dbg     (state_dbg),
    .burst_cnt_dbg (burst_cnt_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver helpers: step lands 2 time units after a rising edge,
  // settle lets combinational outputs follow freshly driven inputs
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] data_of(input int o);
    case (o)
      0: return 4'hA;
      1: return 4'h5;
      2: return 4'hC;
      default: return 4'h3;
    endcase
  endfunction

  // one cycle of an active owner with out_ready high
  task automatic check_owner_xfer(input string tag, input int o, input int cnt);
    check({tag, "_gnt"}, 8'(gnt), 8'(4'b0001 << o));
    check({tag, "_sel"}, 8'(sel), 8'(o));
    check({tag, "_ack"}, 8'(ack), 8'(4'b0001 << o));
    check({tag, "_y"},   8'(y),   8'(data_of(o)));
    check({tag, "_cnt"}, 8'(burst_cnt_dbg), 8'(cnt));
  endtask

  initial begin
    int order [5];
    tests_run    = 0;
    tests_failed = 0;
    order = '{0, 1, 2, 3, 0};

    // reset
    rst_n     = 1'b0;
    req       = 4'b0000;
    a         = 4'hA;
    b         = 4'h5;
    c         = 4'hC;
    d         = 4'h3;
    out_ready = 1'b0;
    #2;
    check("rst_gnt",   8'(gnt), 8'h0);
    check("rst_sel",   8'(sel), 8'h0);
    check("rst_valid", 8'(out_valid), 8'h0);
    check("rst_ack",   8'(ack), 8'h0);
    check("rst_y",     8'(y), 8'hA);
    check("rst_state", 8'(state_dbg), 8'h0);
    check("rst_cnt",   8'(burst_cnt_dbg), 8'h0);
    #20 rst_n = 1'b1;
    step();

    // single requester 0: 1-cycle latency, 4 acks, immediate re-grant
    req       = 4'b0001;
    out_ready = 1'b1;
    settle();
    check("t1_lat_gnt",   8'(gnt), 8'h0);
    check("t1_lat_valid", 8'(out_valid), 8'h0);
    step();
    check("t1_valid", 8'(out_valid), 8'h1);
    for (int k = 0; k < 4; k++) begin
      check_owner_xfer("t1", 0, k);
      step();
    end
    check("t1_regrant_gnt",   8'(gnt), 8'h1);
    check("t1_regrant_state", 8'(state_dbg), 8'h1);
    check("t1_regrant_cnt",   8'(burst_cnt_dbg), 8'h0);

    // all requesting: order 0,1,2,3,0 with 4 acks each, no bubble
    req = 4'b1111;
    settle();
    for (int i = 0; i < 5; i++) begin
      for (int k = 0; k < 4; k++) begin
        check_owner_xfer("t2", order[i], k);
        step();
      end
    end
    check("t2_next_gnt", 8'(gnt), 8'h2);

    // owner 1 stalled by out_ready=0 for 10 cycles after one transfer
    check_owner_xfer("t3_pre", 1, 0);
    step();
    out_ready = 1'b0;
    settle();
    for (int k = 0; k < 10; k++) begin
      check("t3_gnt",   8'(gnt), 8'h2);
      check("t3_valid", 8'(out_valid), 8'h1);
      check("t3_ack",   8'(ack), 8'h0);
      check("t3_cnt",   8'(burst_cnt_dbg), 8'h1);
      step();
    end
    out_ready = 1'b1;
    settle();
    for (int k = 1; k < 4; k++) begin
      check_owner_xfer("t3_post", 1, k);
      step();
    end

    // owner 2 withdraws after 2 transfers, only requester 0 left
    check_owner_xfer("t4", 2, 0);
    step();
    check_owner_xfer("t4", 2, 1);
    step();
    req = 4'b0001;
    settle();
    check("t4_drop_valid", 8'(out_valid), 8'h0);
    check("t4_drop_ack",   8'(ack), 8'h0);
    step();
    check("t4_gnt", 8'(gnt), 8'h1);
    check("t4_sel", 8'(sel), 8'h0);
    check("t4_cnt", 8'(burst_cnt_dbg), 8'h0);

    // pointer rotation: 0 drops -> 2 (scan from 1), 2 drops -> 3 before 0
    out_ready = 1'b0;
    req = 4'b1100;
    settle();
    step();
    check("t4b_gnt_2", 8'(gnt), 8'h4);
    req = 4'b1001;
    settle();
    step();
    check("t4b_gnt_3", 8'(gnt), 8'h8);
    check("t4b_sel_3", 8'(sel), 8'h3);

    // reset mid-burst with owner 3 at burst_cnt=2
    out_ready = 1'b1;
    settle();
    check_owner_xfer("t5", 3, 0);
    step();
    check_owner_xfer("t5", 3, 1);
    step();
    check("t5_cnt2", 8'(burst_cnt_dbg), 8'h2);
    rst_n = 1'b0;
    #1;
    check("t5_rst_gnt",   8'(gnt), 8'h0);
    check("t5_rst_valid", 8'(out_valid), 8'h0);
    check("t5_rst_sel",   8'(sel), 8'h0);
    check("t5_rst_ack",   8'(ack), 8'h0);
    check("t5_rst_cnt",   8'(burst_cnt_dbg), 8'h0);
    req = 4'b1111;
    #1 rst_n = 1'b1;
    step();
    check("t5_first_gnt", 8'(gnt), 8'h1);
    check("t5_first_y",   8'(y), 8'hA);

    // only requester 3, toggling 1,0,1
    req = 4'b1000;
    settle();
    check("t6_valid_drop", 8'(out_valid), 8'h0);
    step();
    check("t6_gnt3", 8'(gnt), 8'h8);
    check("t6_ack3", 8'(ack), 8'h8);
    req = 4'b0000;
    settle();
    check("t6_valid_off", 8'(out_valid), 8'h0);
    step();
    check("t6_idle_gnt",   8'(gnt), 8'h0);
    check("t6_idle_state", 8'(state_dbg), 8'h0);
    step();
    check("t6_idle_gnt2", 8'(gnt), 8'h0);
    req = 4'b1000;
    settle();
    check("t6_lat_gnt", 8'(gnt), 8'h0);
    step();
    check("t6_regnt", 8'(gnt), 8'h8);
    check("t6_sel",   8'(sel), 8'h3);
    check("t6_y",     8'(y), 8'h3);

    // report
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
